restoring_divider6: RTL and testbench

RESTORING_DIVIDER6 -- requirements
Module: restoring_divider6

---
 rtl/restoring_divider6.sv | 140 ++++++++++++++
 tb/tb_restoring_divider6.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/restoring_divider6.sv
// Multi-cycle unsigned restoring divider: 2W-bit dividend / W-bit divisor over a shared input bus.
// Optional DIV_OVF_CHECK_EN flags divide-by-zero and quotient overflow instead of iterating.
module restoring_divider6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inBus,
  output logic [WIDTH-1:0] outBus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLdh  = 3'd1;
  localparam logic [2:0] StLdl  = 3'd2;
  localparam logic [2:0] StLdd  = 3'd3;
  localparam logic [2:0] StChk  = 3'd4;
  localparam logic [2:0] StIter = 3'd5;
  localparam logic [2:0] StOutq = 3'd6;
  localparam logic [2:0] StOutr = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   shift_r;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] out_val;
  logic             out_en;
  logic             unused_r_msb;

  // R only ever holds values below the divisor, so its top bit is shifted out unused.
  assign shift_r      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial        = {1'b0, shift_r} - {2'b00, dvs_q};
  assign unused_r_msb = r_q[WIDTH];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StLdh;
      end
      StLdh: begin
        r_d     = {1'b0, inBus};
        state_d = StLdl;
      end
      StLdl: begin
        q_d     = inBus;
        state_d = StLdd;
      end
      StLdd: begin
        dvs_d   = inBus;
        state_d = StChk;
      end
      StChk: begin
        cnt_d   = '0;
        state_d = StIter;
`ifdef DIV_OVF_CHECK_EN
        err_d = 1'b0;
        if (dvs_q == '0 || r_q[WIDTH-1:0] >= dvs_q) begin
          err_d   = 1'b1;
          state_d = StOutq;
        end
`endif
      end
      StIter: begin
        // Negative trial (sign bit set) means restore the shifted remainder.
        if (!trial[WIDTH+1]) begin
          r_d = trial[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shift_r;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = StOutq;
      end
      StOutq: begin
        state_d = StOutr;
      end
      StOutr: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_en  = (state_q == StOutq) || (state_q == StOutr);
    out_val = (state_q == StOutq) ? q_q : r_q[WIDTH-1:0];
`ifdef DIV_OVF_CHECK_EN
    if (err_q) out_val = '1;
`endif
  end

  assign outBus = out_en ? out_val : {WIDTH{1'bz}};
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StOutr);

`ifdef DIV_OVF_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider6.sv
// Self-checking bench for restoring_divider6: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_restoring_divider6;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] in_bus;
  wire  [5:0] out_bus;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  restoring_divider6 #(.WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst_n),
    .start  (start),
    .inBus  (in_bus),
    .outBus (out_bus),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; poke pulses start during ITER and OUTQ, which must be ignored.
  task automatic run_div(input logic [5:0] hi, input logic [5:0] lo, input logic [5:0] dv,
                         input bit poke, input string tag);
    int         dividend;
    int         exp_busy;
    logic [5:0] eq, er;
    logic       ee;
    int         busy_n, done_n, done_at;
    logic [5:0] prev_out, q_seen, r_seen;
    logic       prev_err, eq_err, er_err;

    dividend = int'({hi, lo});
`ifdef DIV_OVF_CHECK_EN
    if (dv == 0 || hi >= dv) begin
      ee = 1'b1; eq = 6'h3f; er = 6'h3f; exp_busy = 6;
    end else
`endif
    if (dv == 0) begin
      ee = 1'b0; eq = 6'h3f; er = lo; exp_busy = 12;
    end else begin
      ee = 1'b0; eq = 6'(dividend / int'(dv)); er = 6'(dividend % int'(dv)); exp_busy = 12;
    end

    busy_n = 0; done_n = 0; done_at = 0;
    prev_out = '0; prev_err = 1'b0; q_seen = '0; r_seen = '0; eq_err = 1'b0; er_err = 1'b0;

    @(posedge clk); #1;
    start  = 1'b1;
    in_bus = 6'($urandom);
    @(posedge clk); #1;
    start  = 1'b0;
    in_bus = hi;
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) in_bus = lo;
      else if (k == 3) in_bus = dv;
      else if (k > 3) in_bus = 6'($urandom);
      start = poke && (k == 6 || k == 11);
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        q_seen  = prev_out;
        eq_err  = prev_err;
        r_seen  = out_bus;
        er_err  = err;
      end
      prev_out = out_bus;
      prev_err = err;
      if (!busy) break;
      @(posedge clk); #1;
    end
    start = 1'b0;

    chk({tag, " quotient"}, 16'(q_seen), 16'(eq));
    chk({tag, " remainder"}, 16'(r_seen), 16'(er));
    chk({tag, " err@outq"}, 16'(eq_err), 16'(ee));
    chk({tag, " err@outr"}, 16'(er_err), 16'(ee));
    chk({tag, " done count"}, 16'(done_n), 16'd1);
    chk({tag, " busy cycles"}, 16'(busy_n), 16'(exp_busy));
    chk({tag, " done cycle"}, 16'(done_at), 16'(exp_busy));
  endtask

  initial begin
    int         done_seen, busy_seen;
    logic [5:0] hi, lo, dv;

    rst_n  = 1'b0;
    start  = 1'b0;
    in_bus = '0;
    #3;
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset err", 16'(err), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_div(6'h01, 6'h24, 6'h07, 1'b0, "100/7");
    run_div(6'h3e, 6'h3f, 6'h3f, 1'b0, "4031/63");
    run_div(6'h00, 6'h15, 6'h00, 1'b0, "div0");
`ifdef DIV_OVF_CHECK_EN
    run_div(6'h07, 6'h00, 6'h07, 1'b0, "ovf");
`endif
    run_div(6'h01, 6'h24, 6'h07, 1'b1, "poke 100/7");

    // Reset during the third ITER cycle abandons the operation.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    in_bus = 6'h01;
    @(posedge clk); #1;
    in_bus = 6'h24;
    @(posedge clk); #1;
    in_bus = 6'h07;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 16'(busy), 16'd0);
    chk("midreset done", 16'(done), 16'd0);
    chk("midreset err", 16'(err), 16'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("post-reset no done", 16'(done_seen), 16'd0);
    chk("post-reset idle", 16'(busy_seen), 16'd0);
    run_div(6'h01, 6'h24, 6'h07, 1'b0, "restart 100/7");

    for (int i = 0; i < 20; i++) begin
      dv = 6'($urandom_range(1, 63));
      hi = 6'($urandom_range(0, int'(dv) - 1));
      lo = 6'($urandom);
      run_div(hi, lo, dv, i[0], "rand");
    end
`ifdef DIV_OVF_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      dv = 6'($urandom_range(0, 63));
      hi = 6'($urandom_range(int'(dv), 63));
      lo = 6'($urandom);
      run_div(hi, lo, dv, 1'b0, "rand ovf");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
